// File: rtl/mat_addr_gen.sv
// Row-major address sequencer for the matrix-multiply operand ports: walks M1 row and M2 inner
// index with start/done handshake, consumer stall, abort and single-pass or continuous modes.
module mat_addr_gen #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 64,
    parameter int unsigned A1_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int unsigned A2_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            en,
    input  logic            cont,
    output logic [A1_W-1:0] Dir_M1,
    output logic [A2_W-1:0] Dir_M2,
    output logic            valid,
    output logic            row_last,
    output logic            done,
    output logic            busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [A1_W-1:0] M1Last = A1_W'(ROWS - 1);
    localparam logic [A2_W-1:0] M2Last = A2_W'(COLS - 1);

    logic [1:0]      r_state, w_state_d;
    logic [A1_W-1:0] r_m1, w_m1_d;
    logic [A2_W-1:0] r_m2, w_m2_d;
    logic            r_cont, w_cont_d;
    logic            r_valid, w_valid_d;
    logic            r_done, w_done_d;
    logic            r_busy, w_busy_d;

    always_comb begin
        w_state_d = r_state;
        w_m1_d    = r_m1;
        w_m2_d    = r_m2;
        w_cont_d  = r_cont;
        w_valid_d = r_valid;
        w_done_d  = 1'b0;
        w_busy_d  = r_busy;
        case (r_state)
            StIdle: begin
                if (start && !stop) begin
                    w_state_d = StRun;
                    w_cont_d  = cont;
                    w_m1_d    = '0;
                    w_m2_d    = '0;
                    w_valid_d = 1'b1;
                    w_busy_d  = 1'b1;
                end
            end
            StRun: begin
                // stop outranks both the stall and the last-pair transition
                if (stop) begin
                    w_state_d = StIdle;
                    w_m1_d    = '0;
                    w_m2_d    = '0;
                    w_valid_d = 1'b0;
                    w_busy_d  = 1'b0;
                end else if (en) begin
                    if (r_m2 != M2Last) begin
                        w_m2_d = r_m2 + A2_W'(1);
                    end else if (r_m1 != M1Last) begin
                        w_m2_d = '0;
                        w_m1_d = r_m1 + A1_W'(1);
                    end else begin
                        w_m1_d   = '0;
                        w_m2_d   = '0;
                        w_done_d = 1'b1;
                        if (!r_cont) begin
                            w_state_d = StDone;
                            w_valid_d = 1'b0;
                        end
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_m1_d    = '0;
                w_m2_d    = '0;
                w_valid_d = 1'b0;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = StIdle;
                w_m1_d    = '0;
                w_m2_d    = '0;
                w_valid_d = 1'b0;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_m1    <= '0;
            r_m2    <= '0;
            r_cont  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_m1    <= w_m1_d;
            r_m2    <= w_m2_d;
            r_cont  <= w_cont_d;
            r_valid <= w_valid_d;
            r_done  <= w_done_d;
            r_busy  <= w_busy_d;
        end
    end

    assign Dir_M1   = r_m1;
    assign Dir_M2   = r_m2;
    assign valid    = r_valid;
    assign done     = r_done;
    assign busy     = r_busy;
    assign row_last = r_valid && (r_m2 == M2Last);

endmodule

// File: tb/tb_mat_addr_gen.sv
// Directed bench for mat_addr_gen: 4x4, 3x5 and 1x1 instances share clock, reset and controls,
// each with its own start.
module tb_mat_addr_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stop = 1'b0;
    logic en = 1'b1;
    logic cont = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;

    logic [1:0] a_m1, a_m2;
    logic       a_valid, a_rl, a_done, a_busy;
    logic [1:0] b_m1;
    logic [2:0] b_m2;
    logic       b_valid, b_rl, b_done, b_busy;
    logic [0:0] c_m1, c_m2;
    logic       c_valid, c_rl, c_done, c_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mat_addr_gen #(.ROWS(4), .COLS(4)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop), .en(en), .cont(cont),
        .Dir_M1(a_m1), .Dir_M2(a_m2), .valid(a_valid), .row_last(a_rl), .done(a_done),
        .busy(a_busy)
    );

    mat_addr_gen #(.ROWS(3), .COLS(5)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop), .en(en), .cont(cont),
        .Dir_M1(b_m1), .Dir_M2(b_m2), .valid(b_valid), .row_last(b_rl), .done(b_done),
        .busy(b_busy)
    );

    mat_addr_gen #(.ROWS(1), .COLS(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .stop(stop), .en(en), .cont(cont),
        .Dir_M1(c_m1), .Dir_M2(c_m2), .valid(c_valid), .row_last(c_rl), .done(c_done),
        .busy(c_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int m1, input int m2, input logic v,
                           input logic rl, input logic d, input logic b);
        check({tag, ".m1"}, 32'(a_m1), 32'(m1));
        check({tag, ".m2"}, 32'(a_m2), 32'(m2));
        check({tag, ".valid"}, 32'(a_valid), 32'(v));
        check({tag, ".row_last"}, 32'(a_rl), 32'(rl));
        check({tag, ".done"}, 32'(a_done), 32'(d));
        check({tag, ".busy"}, 32'(a_busy), 32'(b));
    endtask

    initial begin
        int fires;
        int cyc;
        logic exp_done;

        // reset values while rst is held
        #2;
        check_a("rst_a", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_b.valid", 32'(b_valid), 32'd0);
        check("rst_c.busy", 32'(c_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single pass 4x4, no stalls
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_a("pass4", i / 4, i % 4, 1'b1, (i % 4) == 3, 1'b0, 1'b1);
            tick();
        end
        check_a("pass4_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_a("pass4_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // same pass with en pattern 1,0,0,1
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        fires = 0;
        cyc = 0;
        while (fires < 16 && cyc < 100) begin
            check_a("stall4", fires / 4, fires % 4, 1'b1, (fires % 4) == 3, 1'b0, 1'b1);
            en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            tick();
            if (en) fires++;
            cyc++;
        end
        check("stall4.fires", 32'(fires), 32'd16);
        en = 1'b1;
        check_a("stall4_done", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_a("stall4_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3x5 continuous, 45 fires
        cont = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cont = 1'b0;
        for (int f = 0; f < 45; f++) begin
            exp_done = (f != 0) && ((f % 15) == 0);
            check("cont35.valid", 32'(b_valid), 32'd1);
            check("cont35.m1", 32'(b_m1), 32'((f % 15) / 5));
            check("cont35.m2", 32'(b_m2), 32'(f % 5));
            check("cont35.done", 32'(b_done), 32'(exp_done));
            check("cont35.row_last", 32'(b_rl), 32'((f % 5) == 4));
            tick();
        end
        check("cont35_end.done", 32'(b_done), 32'd1);
        check("cont35_end.valid", 32'(b_valid), 32'd1);
        check("cont35_end.m1", 32'(b_m1), 32'd0);
        check("cont35_end.m2", 32'(b_m2), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cont35_stop.busy", 32'(b_busy), 32'd0);
        check("cont35_stop.valid", 32'(b_valid), 32'd0);
        check("cont35_stop.done", 32'(b_done), 32'd0);

        // abort at (2,1), then start+stop together in IDLE
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (9) tick();
        check_a("abort_at", 2, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_a("abort_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_a = 1'b1;
        stop = 1'b1;
        tick();
        start_a = 1'b0;
        stop = 1'b0;
        check_a("start_stop", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_a("start_stop2", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-pass at (1,2)
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (6) tick();
        check_a("pre_rst", 1, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_a("async_rst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_a("restart", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_a("restart2", 0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // 1x1 single pass, start held through the done cycle
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("one.valid", 32'(c_valid), 32'd1);
        check("one.row_last", 32'(c_rl), 32'd1);
        check("one.m1", 32'(c_m1), 32'd0);
        check("one.m2", 32'(c_m2), 32'd0);
        tick();
        check("one_done.done", 32'(c_done), 32'd1);
        check("one_done.valid", 32'(c_valid), 32'd0);
        check("one_done.busy", 32'(c_busy), 32'd1);
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("one_idle.busy", 32'(c_busy), 32'd0);
        check("one_idle.done", 32'(c_done), 32'd0);
        check("one_idle.valid", 32'(c_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
